// File: rtl/pattern_sequencer_pkg.sv
// ============================================================================
// Module   : pattern_sequencer_pkg
// Purpose  : Shared FSM encoding, pattern indices and index helpers for the
//            pattern sequencer, generator and overlay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pattern_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } seq_state_t;

  localparam logic [3:0] c_pat_color_bars = 4'd0;
  localparam logic [3:0] c_pat_ramp_h     = 4'd1;
  localparam logic [3:0] c_pat_ramp_v     = 4'd2;
  localparam logic [3:0] c_pat_checker    = 4'd3;
  localparam logic [3:0] c_pat_crosshatch = 4'd4;
  localparam logic [3:0] c_pat_solid_wht  = 4'd5;
  localparam logic [3:0] c_pat_solid_blk  = 4'd6;
  localparam logic [3:0] c_pat_border     = 4'd7;

  // Oldest..newest sample window that marks a debounced press.
  localparam logic [2:0] c_press_pattern = 3'b011;

  function automatic logic [3:0] pat_inc(input logic [3:0] idx, input logic [3:0] last);
    return (idx >= last) ? 4'd0 : idx + 4'd1;
  endfunction

  function automatic logic [3:0] pat_dec(input logic [3:0] idx, input logic [3:0] last);
    return (idx == 4'd0) ? last : idx - 4'd1;
  endfunction

  // Eight-character ASCII label used by the overlay.
  function automatic logic [63:0] pat_name(input logic [3:0] idx);
    case (idx)
      c_pat_color_bars: return "COLORBAR";
      c_pat_ramp_h:     return "RAMP H  ";
      c_pat_ramp_v:     return "RAMP V  ";
      c_pat_checker:    return "CHECKER ";
      c_pat_crosshatch: return "XHATCH  ";
      c_pat_solid_wht:  return "WHITE   ";
      c_pat_solid_blk:  return "BLACK   ";
      c_pat_border:     return "BORDER  ";
      default:          return "PATTERN ";
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_sequencer_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Frame-sampled button debouncer producing a single press pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);
  import pattern_sequencer_pkg::*;

  // The three-sample window is the two stored samples plus the live input on
  // the tick cycle, so a press acts on the same edge as its second high sample.
  logic [1:0] r_hist;
  logic       r_armed;
  logic [2:0] w_window;

  assign w_window = {r_hist, i_btn};

  // Arming requires one released sample, so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist  <= 2'b00;
      r_armed <= 1'b0;
    end else if (i_tick) begin
      r_hist <= w_window[1:0];
      if (!i_btn) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_press = i_tick & r_armed & (w_window == c_press_pattern);

endmodule

`default_nettype wire

// File: rtl/pattern_sequencer.sv
// ============================================================================
// Module   : pattern_sequencer
// Purpose  : Selects the active test pattern via buttons or auto-cycling,
//            stepping only on frame boundaries, with a name-banner timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_sequencer #(
  parameter int NUM_PAT       = 8,
  parameter int AUTO_FRAMES   = 300,
  parameter int BANNER_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_auto,
  output logic [3:0] pattern_sel,
  output logic       auto_mode,
  output logic       banner,
  output logic       frame_tick
);
  import pattern_sequencer_pkg::*;

  localparam logic [3:0] c_last_pat    = 4'(NUM_PAT - 1);
  localparam logic [9:0] c_auto_last   = 10'(AUTO_FRAMES - 1);
  localparam logic [7:0] c_banner_load = 8'(BANNER_FRAMES);

  logic       r_vblank_d;
  seq_state_t r_state;
  logic [3:0] r_pattern_sel;
  logic [9:0] r_frame_cnt;
  logic [7:0] r_banner_cnt;

  logic       w_tick;
  logic       w_press_next;
  logic       w_press_prev;
  logic       w_press_auto;
  seq_state_t w_state_nxt;
  logic [3:0] w_sel_nxt;
  logic [9:0] w_frame_cnt_nxt;
  logic [7:0] w_banner_nxt;

  assign w_tick = vblank & ~r_vblank_d;

  btn_debounce u_db_next (.clk(clk), .reset(reset), .i_tick(w_tick), .i_btn(btn_next), .o_press(w_press_next));
  btn_debounce u_db_prev (.clk(clk), .reset(reset), .i_tick(w_tick), .i_btn(btn_prev), .o_press(w_press_prev));
  btn_debounce u_db_auto (.clk(clk), .reset(reset), .i_tick(w_tick), .i_btn(btn_auto), .o_press(w_press_auto));

  // Mode toggle outranks stepping; a user step outranks a coincident auto-step.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_pattern_sel;
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_tick) begin
      if (w_press_auto) begin
        w_state_nxt     = (r_state == ST_MANUAL) ? ST_AUTO : ST_MANUAL;
        w_frame_cnt_nxt = '0;
      end else if (w_press_next != w_press_prev) begin
        w_sel_nxt   = w_press_next ? pat_inc(r_pattern_sel, c_last_pat)
                                   : pat_dec(r_pattern_sel, c_last_pat);
        w_state_nxt = ST_MANUAL;
      end else if (r_state == ST_AUTO) begin
        if (r_frame_cnt >= c_auto_last) begin
          w_frame_cnt_nxt = '0;
          w_sel_nxt       = pat_inc(r_pattern_sel, c_last_pat);
        end else begin
          w_frame_cnt_nxt = r_frame_cnt + 10'd1;
        end
      end
    end
  end

  always_comb begin
    w_banner_nxt = r_banner_cnt;
    if (w_sel_nxt != r_pattern_sel) begin
      w_banner_nxt = c_banner_load;
    end else if (w_tick && (r_banner_cnt != 8'd0)) begin
      w_banner_nxt = r_banner_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vblank_d    <= 1'b1;
      r_state       <= ST_MANUAL;
      r_pattern_sel <= 4'd0;
      r_frame_cnt   <= '0;
      r_banner_cnt  <= c_banner_load;
    end else begin
      r_vblank_d    <= vblank;
      r_state       <= w_state_nxt;
      r_pattern_sel <= w_sel_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_banner_cnt  <= w_banner_nxt;
    end
  end

  assign pattern_sel = r_pattern_sel;
  assign auto_mode   = (r_state == ST_AUTO);
  assign banner      = (r_banner_cnt != 8'd0);
  assign frame_tick  = w_tick;

endmodule

`default_nettype wire
